// File: rtl/stream_minmax_if.sv
// ---------------------------------------------------------------------------
// stream_minmax_if
//   Bundles the sample stream, the result stream and the status flag of
//   stream_minmax into one interface.
//
//   Parameters:
//     WIDTH - sample width in bits
//     LEN   - samples per window (sets the width of out_index)
//
//   Signals:
//     in_valid / in_ready / in_data  - sample handshake (producer -> block)
//     mode                           - 0 = minimum, 1 = maximum
//     out_valid / out_ready          - result handshake (block -> consumer)
//     out_data / out_index           - winning value and its window position
//     busy                           - a window is partially accumulated
//
//   Modports:
//     master - the side that feeds samples and consumes results
//     slave  - the stream_minmax block itself
// ---------------------------------------------------------------------------
interface stream_minmax_if #(
    parameter int WIDTH = 8,
    parameter int LEN   = 16
);
    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IW-1:0]    out_index;
    logic             busy;

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data, out_index, busy
    );

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data, out_index, busy
    );
endinterface

// File: rtl/stream_minmax.sv
// ---------------------------------------------------------------------------
// stream_minmax
//   Collects windows of LEN samples from a valid/ready stream and reports the
//   minimum (mode = 0) or maximum (mode = 1) sample of each window together
//   with its position inside the window. Ties keep the earliest position.
//   The mode sampled with the first sample of a window governs that window.
//
//   Parameters:
//     WIDTH  - sample width in bits (>= 2)
//     LEN    - samples per window (>= 1)
//     SIGNED - 0 = unsigned compare, 1 = two's-complement compare
//
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous, active-high reset
//     s   - stream_minmax_if.slave (sample stream, result stream, busy)
// ---------------------------------------------------------------------------
module stream_minmax #(
    parameter int WIDTH  = 8,
    parameter int LEN    = 16,
    parameter int SIGNED = 0
) (
    input  logic           clk,
    input  logic           rst,
    stream_minmax_if.slave s
);
    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
    // count must be able to hold LEN itself, hence LEN+1 codes
    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] best, best_n;
    logic [IW-1:0]    best_idx, best_idx_n;
    logic             mode_r, mode_n;

    logic xfer;
    logic less;
    logic greater;
    logic better;

    // Compare rule is fixed at elaboration time by SIGNED.
    generate
        if (SIGNED != 0) begin : g_signed
            assign less    = $signed(s.in_data) < $signed(best);
            assign greater = $signed(s.in_data) > $signed(best);
        end else begin : g_unsigned
            assign less    = s.in_data < best;
            assign greater = s.in_data > best;
        end
    endgenerate

    // Strict comparison so that a tie never displaces the earlier winner.
    assign better = mode_r ? greater : less;
    assign xfer   = s.in_valid && s.in_ready;

    // Outputs are decoded from the state, and forced low while rst is high
    // so nothing leaks out during reset. Result fields read zero unless the
    // result is being offered.
    always_comb begin
        s.in_ready  = 1'b0;
        s.busy      = 1'b0;
        s.out_valid = 1'b0;
        s.out_data  = '0;
        s.out_index = '0;
        if (!rst) begin
            s.in_ready = (state != DONE);
            s.busy     = (state == ACCUM);
            if (state == DONE) begin
                s.out_valid = 1'b1;
                s.out_data  = best;
                s.out_index = best_idx;
            end
        end
    end

    // Next-state logic. The LEN-th sample is folded into the comparison on
    // the same edge that moves to DONE, so the result shows up one cycle
    // after the last transfer.
    always_comb begin
        state_n    = state;
        count_n    = count;
        best_n     = best;
        best_idx_n = best_idx;
        mode_n     = mode_r;
        case (state)
            IDLE: begin
                if (xfer) begin
                    best_n     = s.in_data;
                    best_idx_n = '0;
                    count_n    = CW'(1);
                    mode_n     = s.mode;
                    state_n    = (LEN == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    if (better) begin
                        best_n     = s.in_data;
                        best_idx_n = IW'(count);
                    end
                    count_n = count + CW'(1);
                    if (count == LAST) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (s.out_ready) begin
                    count_n = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset drops any partial or
    // pending window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            best     <= '0;
            best_idx <= '0;
            mode_r   <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            best     <= best_n;
            best_idx <= best_idx_n;
            mode_r   <= mode_n;
        end
    end
endmodule
